// File: rtl/alu_issue_scheduler.sv
// Reservation-station scheduler for one shared integer ALU: dispatch, CDB wakeup, round-robin select.
// Optional `define ISSUE_PERF_CNT_EN adds the perf_issued / perf_full_stall counters.
module alu_issue_scheduler #(
    parameter int RS_DEPTH = 8,
    parameter int TAG_W    = 6,
    parameter int DATA_W   = 32,
    parameter int ROB_W    = 5
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        flush,
    input  logic                        disp_valid,
    output logic                        disp_ready,
    input  logic [6:0]                  disp_opcode,
    input  logic [2:0]                  disp_funct3,
    input  logic [6:0]                  disp_funct7,
    input  logic [TAG_W-1:0]            disp_src1_tag,
    input  logic [TAG_W-1:0]            disp_src2_tag,
    input  logic                        disp_src1_rdy,
    input  logic                        disp_src2_rdy,
    input  logic [DATA_W-1:0]           disp_src1_val,
    input  logic [DATA_W-1:0]           disp_src2_val,
    input  logic [31:0]                 disp_imm,
    input  logic                        disp_has_imm,
    input  logic [TAG_W-1:0]            disp_dest_tag,
    input  logic [ROB_W-1:0]            disp_rob_idx,
    input  logic                        cdb_valid,
    input  logic [TAG_W-1:0]            cdb_tag,
    input  logic [DATA_W-1:0]           cdb_data,
    output logic                        issue_valid,
    input  logic                        issue_ready,
    output logic [6:0]                  issue_opcode,
    output logic [2:0]                  issue_funct3,
    output logic [6:0]                  issue_funct7,
    output logic [DATA_W-1:0]           issue_op_a,
    output logic [DATA_W-1:0]           issue_op_b,
    output logic [TAG_W-1:0]            issue_dest_tag,
    output logic [ROB_W-1:0]            issue_rob_idx,
    output logic [$clog2(RS_DEPTH):0]   occupancy,
    output logic [31:0]                 perf_issued,
    output logic [31:0]                 perf_full_stall
);
    localparam int PTR_W = $clog2(RS_DEPTH);
    localparam int OCC_W = PTR_W + 1;

    logic [RS_DEPTH-1:0] vld, s1_rdy, s2_rdy, has_imm;
    logic [6:0]          e_opcode [RS_DEPTH];
    logic [2:0]          e_funct3 [RS_DEPTH];
    logic [6:0]          e_funct7 [RS_DEPTH];
    logic [TAG_W-1:0]    s1_tag   [RS_DEPTH];
    logic [TAG_W-1:0]    s2_tag   [RS_DEPTH];
    logic [DATA_W-1:0]   s1_val   [RS_DEPTH];
    logic [DATA_W-1:0]   s2_val   [RS_DEPTH];
    logic [31:0]         e_imm    [RS_DEPTH];
    logic [TAG_W-1:0]    e_dest   [RS_DEPTH];
    logic [ROB_W-1:0]    e_rob    [RS_DEPTH];

    logic [PTR_W-1:0] rr_ptr, lock_idx, sel, scan_idx, free_idx;
    logic             lock, found, do_disp, do_issue, cdb_hit;
    logic [DATA_W:0]  src1_cap, src2_cap;

    // Returns {ready, value} for a source as it is written at dispatch, including CDB bypass.
    function automatic logic [DATA_W:0] capture_src(
        input logic [TAG_W-1:0]  tag,
        input logic              rdy,
        input logic [DATA_W-1:0] val,
        input logic              bc_valid,
        input logic [TAG_W-1:0]  bc_tag,
        input logic [DATA_W-1:0] bc_data
    );
        if (tag == '0) return {1'b1, {DATA_W{1'b0}}};
        if (rdy) return {1'b1, val};
        if (bc_valid && bc_tag == tag) return {1'b1, bc_data};
        return {1'b0, val};
    endfunction

    assign disp_ready = (occupancy < OCC_W'(RS_DEPTH));
    assign do_disp    = disp_valid && disp_ready && !flush;
    assign do_issue   = issue_valid && issue_ready;
    assign cdb_hit    = cdb_valid && (cdb_tag != '0);
    assign src1_cap   = capture_src(disp_src1_tag, disp_src1_rdy, disp_src1_val, cdb_valid, cdb_tag, cdb_data);
    assign src2_cap   = capture_src(disp_src2_tag, disp_src2_rdy, disp_src2_val, cdb_valid, cdb_tag, cdb_data);

    // Lowest-index free entry; entries freed by this cycle's issue still count as occupied.
    always_comb begin
        free_idx = '0;
        for (int i = RS_DEPTH - 1; i >= 0; i--) begin
            if (!vld[i]) free_idx = PTR_W'(i);
        end
    end

    // Downward scan so the smallest offset from rr_ptr wins; a held grant overrides the search.
    always_comb begin
        found    = 1'b0;
        sel      = rr_ptr;
        scan_idx = '0;
        for (int i = RS_DEPTH - 1; i >= 0; i--) begin
            scan_idx = rr_ptr + PTR_W'(i);
            if (vld[scan_idx] && s1_rdy[scan_idx] && s2_rdy[scan_idx]) begin
                found = 1'b1;
                sel   = scan_idx;
            end
        end
        if (lock) begin
            found = 1'b1;
            sel   = lock_idx;
        end
    end

    assign issue_valid = found && !flush;

    always_comb begin
        issue_opcode   = '0;
        issue_funct3   = '0;
        issue_funct7   = '0;
        issue_op_a     = '0;
        issue_op_b     = '0;
        issue_dest_tag = '0;
        issue_rob_idx  = '0;
        if (issue_valid) begin
            issue_opcode   = e_opcode[sel];
            issue_funct3   = e_funct3[sel];
            issue_funct7   = e_funct7[sel];
            issue_op_a     = s1_val[sel];
            issue_op_b     = has_imm[sel] ? DATA_W'(e_imm[sel]) : s2_val[sel];
            issue_dest_tag = e_dest[sel];
            issue_rob_idx  = e_rob[sel];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            vld       <= '0;
            lock      <= 1'b0;
            lock_idx  <= '0;
            rr_ptr    <= '0;
            occupancy <= '0;
        end else if (flush) begin
            vld       <= '0;
            lock      <= 1'b0;
            rr_ptr    <= '0;
            occupancy <= '0;
        end else begin
            if (do_issue) begin
                vld[sel] <= 1'b0;
                rr_ptr   <= sel + 1'b1;
                lock     <= 1'b0;
            end else if (issue_valid) begin
                lock     <= 1'b1;
                lock_idx <= sel;
            end
            if (do_disp) vld[free_idx] <= 1'b1;
            occupancy <= occupancy + OCC_W'(do_disp) - OCC_W'(do_issue);
        end
    end

    // Entry payload and ready bits; only meaningful while vld is set, so not reset.
    always_ff @(posedge clk) begin
        for (int i = 0; i < RS_DEPTH; i++) begin
            if (vld[i] && cdb_hit) begin
                if (!s1_rdy[i] && s1_tag[i] == cdb_tag) begin
                    s1_rdy[i] <= 1'b1;
                    s1_val[i] <= cdb_data;
                end
                if (!s2_rdy[i] && s2_tag[i] == cdb_tag) begin
                    s2_rdy[i] <= 1'b1;
                    s2_val[i] <= cdb_data;
                end
            end
        end
        if (do_disp) begin
            e_opcode[free_idx] <= disp_opcode;
            e_funct3[free_idx] <= disp_funct3;
            e_funct7[free_idx] <= disp_funct7;
            s1_tag[free_idx]   <= disp_src1_tag;
            s2_tag[free_idx]   <= disp_src2_tag;
            s1_rdy[free_idx]   <= src1_cap[DATA_W];
            s1_val[free_idx]   <= src1_cap[DATA_W-1:0];
            s2_rdy[free_idx]   <= disp_has_imm | src2_cap[DATA_W];
            s2_val[free_idx]   <= src2_cap[DATA_W-1:0];
            e_imm[free_idx]    <= disp_imm;
            has_imm[free_idx]  <= disp_has_imm;
            e_dest[free_idx]   <= disp_dest_tag;
            e_rob[free_idx]    <= disp_rob_idx;
        end
    end

`ifdef ISSUE_PERF_CNT_EN
    logic [31:0] issued_cnt, stall_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            issued_cnt <= '0;
            stall_cnt  <= '0;
        end else begin
            if (do_issue) issued_cnt <= issued_cnt + 32'd1;
            if (disp_valid && !disp_ready) stall_cnt <= stall_cnt + 32'd1;
        end
    end

    assign perf_issued     = issued_cnt;
    assign perf_full_stall = stall_cnt;
`else
    assign perf_issued     = '0;
    assign perf_full_stall = '0;
`endif

endmodule

// File: tb/tb_alu_issue_scheduler.sv
// Bench for alu_issue_scheduler: directed scenarios plus random traffic against a behavioural model.
module tb_alu_issue_scheduler;
    localparam int D  = 8;
    localparam int TW = 6;
    localparam int DW = 32;
    localparam int RW = 5;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst, flush, disp_valid, disp_ready;
    logic [6:0]    disp_opcode, disp_funct7;
    logic [2:0]    disp_funct3;
    logic [TW-1:0] disp_src1_tag, disp_src2_tag, disp_dest_tag;
    logic          disp_src1_rdy, disp_src2_rdy, disp_has_imm;
    logic [DW-1:0] disp_src1_val, disp_src2_val;
    logic [31:0]   disp_imm;
    logic [RW-1:0] disp_rob_idx;
    logic          cdb_valid;
    logic [TW-1:0] cdb_tag;
    logic [DW-1:0] cdb_data;
    logic          issue_valid, issue_ready;
    logic [6:0]    issue_opcode, issue_funct7;
    logic [2:0]    issue_funct3;
    logic [DW-1:0] issue_op_a, issue_op_b;
    logic [TW-1:0] issue_dest_tag;
    logic [RW-1:0] issue_rob_idx;
    logic [3:0]    occupancy;
    logic [31:0]   perf_issued, perf_full_stall;

    alu_issue_scheduler #(.RS_DEPTH(D), .TAG_W(TW), .DATA_W(DW), .ROB_W(RW)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .disp_valid(disp_valid), .disp_ready(disp_ready),
        .disp_opcode(disp_opcode), .disp_funct3(disp_funct3), .disp_funct7(disp_funct7),
        .disp_src1_tag(disp_src1_tag), .disp_src2_tag(disp_src2_tag),
        .disp_src1_rdy(disp_src1_rdy), .disp_src2_rdy(disp_src2_rdy),
        .disp_src1_val(disp_src1_val), .disp_src2_val(disp_src2_val),
        .disp_imm(disp_imm), .disp_has_imm(disp_has_imm),
        .disp_dest_tag(disp_dest_tag), .disp_rob_idx(disp_rob_idx),
        .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_data(cdb_data),
        .issue_valid(issue_valid), .issue_ready(issue_ready),
        .issue_opcode(issue_opcode), .issue_funct3(issue_funct3), .issue_funct7(issue_funct7),
        .issue_op_a(issue_op_a), .issue_op_b(issue_op_b),
        .issue_dest_tag(issue_dest_tag), .issue_rob_idx(issue_rob_idx),
        .occupancy(occupancy), .perf_issued(perf_issued), .perf_full_stall(perf_full_stall)
    );

    int total = 0;
    int bad   = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h want=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Behavioural model: a table of station entries plus the round-robin pointer and hold state.
    typedef struct {
        bit            vld, r1, r2, himm;
        logic [TW-1:0] t1, t2, dest;
        logic [DW-1:0] v1, v2;
        logic [31:0]   imm;
        logic [6:0]    op, f7;
        logic [2:0]    f3;
        logic [RW-1:0] rob;
    } ent_t;

    ent_t        ent[D];
    int          m_rr = 0, m_lidx = 0;
    bit          m_lock = 0;
    int unsigned m_issued = 0, m_stall = 0;

    function automatic int live();
        int n = 0;
        for (int k = 0; k < D; k++) if (ent[k].vld) n++;
        return n;
    endfunction

    function automatic int pick();
        if (m_lock) return m_lidx;
        for (int k = 0; k < D; k++) begin
            int j = (m_rr + k) % D;
            if (ent[j].vld && ent[j].r1 && ent[j].r2) return j;
        end
        return -1;
    endfunction

    function automatic logic [32:0] cap(input logic [TW-1:0] t, input logic r, input logic [31:0] v);
        if (t == 0) return {1'b1, 32'd0};
        if (r) return {1'b1, v};
        if (cdb_valid && cdb_tag == t) return {1'b1, cdb_data};
        return {1'b0, v};
    endfunction

    task automatic model_clear();
        for (int k = 0; k < D; k++) ent[k].vld = 0;
        m_lock = 0;
        m_rr   = 0;
    endtask

    // Inputs are already applied (just after negedge); compare, then step the model on the edge.
    task automatic cycle(input bit chk);
        int sel, s, fi;
        bit ev, er;
        logic [32:0] c1, c2;
        #1;
        sel = pick();
        s   = (sel < 0) ? 0 : sel;
        er  = (live() < D);
        ev  = (sel >= 0) && !flush;
        if (chk) begin
            check_eq("disp_ready", 64'(disp_ready), 64'(er));
            check_eq("occupancy", 64'(occupancy), 64'(live()));
            check_eq("issue_valid", 64'(issue_valid), 64'(ev));
            check_eq("opcode", 64'(issue_opcode), ev ? 64'(ent[s].op) : 64'd0);
            check_eq("funct3", 64'(issue_funct3), ev ? 64'(ent[s].f3) : 64'd0);
            check_eq("funct7", 64'(issue_funct7), ev ? 64'(ent[s].f7) : 64'd0);
            check_eq("op_a", 64'(issue_op_a), ev ? 64'(ent[s].v1) : 64'd0);
            check_eq("op_b", 64'(issue_op_b), ev ? (ent[s].himm ? 64'(ent[s].imm) : 64'(ent[s].v2)) : 64'd0);
            check_eq("dest_tag", 64'(issue_dest_tag), ev ? 64'(ent[s].dest) : 64'd0);
            check_eq("rob_idx", 64'(issue_rob_idx), ev ? 64'(ent[s].rob) : 64'd0);
`ifdef ISSUE_PERF_CNT_EN
            check_eq("perf_issued", 64'(perf_issued), 64'(m_issued));
            check_eq("perf_full_stall", 64'(perf_full_stall), 64'(m_stall));
`else
            check_eq("perf_issued", 64'(perf_issued), 64'd0);
            check_eq("perf_full_stall", 64'(perf_full_stall), 64'd0);
`endif
        end
        @(posedge clk);
        if (rst) begin
            model_clear();
            m_lidx   = 0;
            m_issued = 0;
            m_stall  = 0;
        end else begin
            if (disp_valid && !er) m_stall++;
            if (flush) begin
                model_clear();
            end else begin
                fi = -1;
                for (int k = D - 1; k >= 0; k--) if (!ent[k].vld) fi = k;
                for (int k = 0; k < D; k++) begin
                    if (ent[k].vld && cdb_valid && cdb_tag != 0) begin
                        if (!ent[k].r1 && ent[k].t1 == cdb_tag) begin ent[k].r1 = 1; ent[k].v1 = cdb_data; end
                        if (!ent[k].r2 && ent[k].t2 == cdb_tag) begin ent[k].r2 = 1; ent[k].v2 = cdb_data; end
                    end
                end
                if (ev && issue_ready) begin
                    ent[sel].vld = 0;
                    m_rr   = (sel + 1) % D;
                    m_lock = 0;
                    m_issued++;
                end else if (ev) begin
                    m_lock = 1;
                    m_lidx = sel;
                end
                if (disp_valid && er && fi >= 0) begin
                    c1 = cap(disp_src1_tag, disp_src1_rdy, disp_src1_val);
                    c2 = cap(disp_src2_tag, disp_src2_rdy, disp_src2_val);
                    ent[fi].vld  = 1;
                    ent[fi].t1   = disp_src1_tag;
                    ent[fi].t2   = disp_src2_tag;
                    ent[fi].r1   = c1[32];
                    ent[fi].v1   = c1[31:0];
                    ent[fi].r2   = c2[32] || disp_has_imm;
                    ent[fi].v2   = c2[31:0];
                    ent[fi].himm = disp_has_imm;
                    ent[fi].imm  = disp_imm;
                    ent[fi].op   = disp_opcode;
                    ent[fi].f3   = disp_funct3;
                    ent[fi].f7   = disp_funct7;
                    ent[fi].dest = disp_dest_tag;
                    ent[fi].rob  = disp_rob_idx;
                end
            end
        end
        @(negedge clk);
    endtask

    task automatic idle();
        rst = 0; flush = 0; disp_valid = 0; issue_ready = 0; cdb_valid = 0;
        disp_opcode = 7'h33; disp_funct3 = 3'd0; disp_funct7 = 7'd0;
        disp_src1_tag = '0; disp_src2_tag = '0; disp_src1_rdy = 0; disp_src2_rdy = 0;
        disp_src1_val = '0; disp_src2_val = '0; disp_imm = '0; disp_has_imm = 0;
        disp_dest_tag = '0; disp_rob_idx = '0; cdb_tag = '0; cdb_data = '0;
    endtask

    task automatic rand_inputs();
        rst           = 0;
        flush         = ($urandom_range(0, 59) == 0);
        disp_valid    = ($urandom_range(0, 2) != 0);
        disp_opcode   = 7'($urandom);
        disp_funct3   = 3'($urandom);
        disp_funct7   = 7'($urandom);
        disp_src1_tag = TW'($urandom_range(0, 7));
        disp_src2_tag = TW'($urandom_range(0, 7));
        disp_src1_rdy = ($urandom_range(0, 3) == 0);
        disp_src2_rdy = ($urandom_range(0, 3) == 0);
        disp_src1_val = $urandom;
        disp_src2_val = $urandom;
        disp_has_imm  = ($urandom_range(0, 2) == 0);
        disp_imm      = $urandom;
        disp_dest_tag = TW'($urandom);
        disp_rob_idx  = RW'($urandom);
        cdb_valid     = ($urandom_range(0, 1) == 1);
        cdb_tag       = TW'($urandom_range(1, 7));
        cdb_data      = $urandom;
        issue_ready   = ($urandom_range(0, 3) != 0);
        // An already-valid source that is also on the CDB carries the same value.
        if (cdb_valid && disp_src1_rdy && disp_src1_tag == cdb_tag) disp_src1_val = cdb_data;
        if (cdb_valid && disp_src2_rdy && disp_src2_tag == cdb_tag) disp_src2_val = cdb_data;
    endtask

    task automatic do_reset();
        idle(); rst = 1;
        cycle(0);
        cycle(0);
        idle();
    endtask

    initial begin
        do_reset();
        #1;
        check_eq("reset_issue_valid", 64'(issue_valid), 64'd0);
        check_eq("reset_disp_ready", 64'(disp_ready), 64'd1);
        check_eq("reset_occupancy", 64'(occupancy), 64'd0);
        cycle(1);

        // ADD with src1 = x0 and src2 ready = 5.
        disp_valid = 1; disp_src2_tag = 6'd3; disp_src2_rdy = 1; disp_src2_val = 32'd5; disp_rob_idx = 5'd11;
        cycle(1);
        idle(); issue_ready = 1;
        #1;
        check_eq("add_valid", 64'(issue_valid), 64'd1);
        check_eq("add_op_b", 64'(issue_op_b), 64'd5);
        check_eq("add_rob", 64'(issue_rob_idx), 64'd11);
        cycle(1);
        cycle(1);

        // CDB wakeup two cycles after dispatch.
        disp_valid = 1; disp_src1_tag = 6'd9;
        cycle(1);
        idle(); cycle(1);
        cdb_valid = 1; cdb_tag = 6'd9; cdb_data = 32'h1234;
        cycle(1);
        idle(); issue_ready = 1;
        #1;
        check_eq("wake_op_a", 64'(issue_op_a), 64'h1234);
        cycle(1);

        // Dispatch bypass from a same-cycle broadcast.
        idle(); disp_valid = 1; disp_src1_tag = 6'd7; cdb_valid = 1; cdb_tag = 6'd7; cdb_data = 32'hAA;
        cycle(1);
        idle(); issue_ready = 1;
        #1;
        check_eq("bypass_op_a", 64'(issue_op_a), 64'hAA);
        cycle(1);

        // Fill all entries with the ALU stalled, then drain with dispatch still offered.
        idle(); flush = 1; cycle(1);
        idle();
        for (int i = 0; i < D; i++) begin
            disp_valid = 1; disp_rob_idx = RW'(i); disp_src2_val = 32'(i);
            cycle(1);
        end
        #1;
        check_eq("full_disp_ready", 64'(disp_ready), 64'd0);
        cycle(1);
        issue_ready = 1;
        for (int i = 0; i < 12; i++) cycle(1);

        // Flush with four live entries, dispatch and issue offered together.
        idle(); flush = 1; cycle(1);
        idle();
        for (int i = 0; i < 4; i++) begin
            disp_valid = 1; disp_src1_tag = 6'd5; cycle(1);
        end
        flush = 1; disp_valid = 1; issue_ready = 1; disp_src1_tag = 6'd0;
        cycle(1);
        idle();
        #1;
        check_eq("flush_occupancy", 64'(occupancy), 64'd0);
        check_eq("flush_issue_valid", 64'(issue_valid), 64'd0);
        cycle(1);

        // Performance counters: 3 full-stall cycles then 4 issues.
        do_reset();
        for (int i = 0; i < D; i++) begin
            disp_valid = 1; cycle(1);
        end
        for (int i = 0; i < 3; i++) cycle(1);
        disp_valid = 0; issue_ready = 1;
        for (int i = 0; i < 4; i++) cycle(1);
        issue_ready = 0;
        #1;
`ifdef ISSUE_PERF_CNT_EN
        check_eq("perf_stall_3", 64'(perf_full_stall), 64'd3);
        check_eq("perf_issued_4", 64'(perf_issued), 64'd4);
`else
        check_eq("perf_stall_off", 64'(perf_full_stall), 64'd0);
        check_eq("perf_issued_off", 64'(perf_issued), 64'd0);
`endif
        cycle(1);

        // Random traffic.
        for (int i = 0; i < 3000; i++) begin
            rand_inputs();
            if (i == 1500) rst = 1;
            cycle(1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/alu_issue_scheduler.md
Name: alu_issue_scheduler

Overview:
Reservation-station scheduler that sits between decode/rename and the single shared integer ALU. It buffers up to RS_DEPTH decoded ALU ops and captures operand results from the common data bus (CDB). Each cycle it selects one fully-ready entry, round-robin, and issues it to the ALU over a valid/ready handshake.

Parameters:
RS_DEPTH, 8, number of station entries (power of 2, >=2)
TAG_W, 6, physical-register tag width; tag 0 = x0, always ready, value 0
DATA_W, 32, operand width
ROB_W, 5, ROB index width

Ports:
clk  in  1  clock; all state updates on rising edge
rst  in  1  synchronous active-high reset
flush  in  1  synchronous squash of all entries
disp_valid  in  1  decoded op offered
disp_ready  out  1  free entry exists
disp_opcode/disp_funct3/disp_funct7  in  7/3/7  decoded fields
disp_src1_tag, disp_src2_tag  in  TAG_W each  source tags
disp_src1_rdy, disp_src2_rdy  in  1 each  source value already valid
disp_src1_val, disp_src2_val  in  DATA_W each  source values (valid when rdy)
disp_imm  in  32  immediate; disp_has_imm  in  1  operand B is imm
disp_dest_tag  in  TAG_W; disp_rob_idx  in  ROB_W
cdb_valid  in  1; cdb_tag  in  TAG_W; cdb_data  in  DATA_W  result broadcast
issue_valid  out  1; issue_ready  in  1  ALU handshake
issue_opcode/issue_funct3/issue_funct7  out  7/3/7
issue_op_a, issue_op_b  out  DATA_W each
issue_dest_tag  out  TAG_W; issue_rob_idx  out  ROB_W
occupancy  out  clog2(RS_DEPTH)+1  valid-entry count
perf_issued, perf_full_stall  out  32 each  see Optional Feature

Behaviour:
- Reset (rst=1): all entry valids 0, rr_ptr=0, lock=0, occupancy=0. Outputs: issue_valid=0, all issue_* data=0, disp_ready=1.
- Per-entry state: valid, op fields, s1_rdy/s1_val, s2_rdy/s2_val, imm, has_imm, dest_tag, rob_idx.
- Dispatch:
  - disp_ready = (occupancy < RS_DEPTH), computed from registered state only.
  - An entry freed by issue in the same cycle is NOT reusable that cycle.
  - Accept on disp_valid && disp_ready; write into the lowest-index free entry.
  - A source is stored ready if its tag==0 (value 0), its rdy==1, or cdb_valid && cdb_tag==tag in that cycle (capture cdb_data; dispatch bypass).
  - has_imm=1: src2 forced ready; operand B = imm.
- Wakeup:
  - Every valid entry with a not-ready src whose tag==cdb_tag (cdb_valid=1, tag!=0) latches cdb_data and sets rdy.
  - Both sources may wake in the same cycle.
- Eligibility is evaluated on registered rdy bits. An entry woken or dispatched at edge N is first eligible in cycle N+1, so minimum dispatch-to-issue latency is 1 cycle.
- Select:
  - Search entries from rr_ptr upward, wrapping, for the first with valid && s1_rdy && s2_rdy.
  - issue_valid = a candidate exists; issue_* driven from the chosen entry, all 0 when issue_valid=0.
  - op_a = s1_val; op_b = has_imm ? imm : s2_val.
- Hold:
  - If issue_valid && !issue_ready, set lock=1 and latch the selected index.
  - While locked, the same entry and identical outputs are presented until accepted.
- Accept:
  - On issue_valid && issue_ready, free the entry, rr_ptr <= (sel+1) mod RS_DEPTH, lock <= 0.
  - occupancy updates by +accepted_dispatch −accepted_issue; simultaneous dispatch and issue leaves it unchanged.
- Flush:
  - Clears all valids, lock, and rr_ptr.
  - Overrides any dispatch or issue in the same cycle; issue_valid is forced 0 during that cycle.
  - Flush has lower priority than rst.
- Full: disp_ready=0; disp_valid is ignored and the upstream stage holds.
- Empty: issue_valid=0. CDB traffic with no matching entry has no effect.

Optional Feature:
ISSUE_PERF_CNT_EN
- Defined: perf_issued increments on each accepted issue; perf_full_stall increments on each cycle with disp_valid && !disp_ready. Both are 32-bit, wrap at 2^32, and are cleared by rst only (not by flush).
- Undefined: no counter flops; both ports tied to 0.

Test Plan:
- Reset, then dispatch ADD with src1 tag0, src2 rdy val=5 -> cycle+1 issue_valid=1, op_a=0, op_b=5, rob_idx echoes; occupancy returns to 0 after accept.
- Dispatch op with src1 tag=9 not ready; CDB tag=9 data=0x1234 two cycles later -> issue_valid rises the cycle after the broadcast with op_a=0x1234.
- Dispatch with src tag=7 not ready while cdb_valid tag=7 data=0xAA in the same cycle (bypass) -> entry ready, issues next cycle with op_a=0xAA.
- Fill 8 entries all ready with issue_ready=0 -> disp_ready=0, outputs frozen on entry 0 (lock); raise issue_ready -> entries 0,1,2… issue in order and rr_ptr wraps 7->0; disp_ready returns to 1 after the first accept and not in the accept cycle.
- Four entries valid, assert flush together with disp_valid and issue_ready -> next cycle occupancy=0, issue_valid=0, no dispatch accepted.
- With ISSUE_PERF_CNT_EN: hold full for 3 cycles with disp_valid=1, then issue 4 -> perf_full_stall=3, perf_issued=4; without the macro both read 0.
